// File: rtl/bp_upd_sched_pkg.sv
// Shared types for the branch-predictor update scheduler: queued update entry and FSM states.
package bp_upd_sched_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            cond;
        logic            taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tpc;
    } bp_upd_entry_t;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bp_upd_state_t;

endpackage

// File: rtl/bp_upd_sched_fifo.sv
// Circular buffer: up to N pushes and WR_PORTS pops per cycle, exposes the head window,
// the tail entry and the occupancy; the tail entry's taken/tpc can be rewritten in place.
module bp_upd_fifo
    import bp_upd_sched_pkg::*;
#(
    parameter int N        = 3,
    parameter int DEPTH    = 8,
    parameter int WR_PORTS = 1,
    parameter int AW       = $clog2(DEPTH),
    parameter int CW       = $clog2(N + 1),
    parameter int PW       = $clog2(WR_PORTS + 1)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CW-1:0]                  push_cnt,
    input  bp_upd_entry_t [N-1:0]          push_data,
    input  logic                           ovr_en,
    input  logic                           ovr_taken,
    input  logic [XLEN-1:0]                ovr_tpc,
    input  logic [PW-1:0]                  pop_cnt,
    output bp_upd_entry_t [WR_PORTS-1:0]   head_win,
    output bp_upd_entry_t                  tail_pkt,
    output logic [AW:0]                    count
);

    bp_upd_entry_t mem_q [DEPTH];
    bp_upd_entry_t mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        // The overwrite target is the previous tail, never a slot written this cycle.
        if (ovr_en) begin
            mem_d[tail_q - AW'(1)].taken = ovr_taken;
            mem_d[tail_q - AW'(1)].tpc   = ovr_tpc;
        end
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < push_cnt) mem_d[tail_q + AW'(i)] = push_data[i];
        end
        head_d  = head_q + AW'(pop_cnt);
        tail_d  = tail_q + AW'(push_cnt);
        count_d = count_q + (AW + 1)'(push_cnt) - (AW + 1)'(pop_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) mem_q <= mem_d;

    always_comb begin
        for (int k = 0; k < WR_PORTS; k++) head_win[k] = mem_q[head_q + AW'(k)];
    end

    assign tail_pkt = mem_q[tail_q - AW'(1)];
    assign count    = count_q;

endmodule

// File: rtl/bp_upd_sched.sv
// Branch-predictor update scheduler: buffers EX-resolved branches, drains them to the tables,
// and runs the table-clear sweep. Define BP_UPD_COALESCE_EN to merge same-pc cond updates.
module bp_upd_sched
    import bp_upd_sched_pkg::*;
#(
    parameter int N        = 3,
    parameter int DEPTH    = 8,
    parameter int WR_PORTS = 1,
    parameter int IDX_BITS = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N-1:0]                  ex_valid,
    input  logic [N-1:0]                  ex_cond,
    input  logic [N-1:0]                  ex_taken,
    input  logic [N-1:0][XLEN-1:0]        ex_pc,
    input  logic [N-1:0][XLEN-1:0]        ex_tpc,
    output logic                          ex_ready,
    input  logic                          flush_req,
    input  logic                          tbl_stall,
    output logic [WR_PORTS-1:0]           upd_valid,
    output bp_upd_entry_t [WR_PORTS-1:0]  upd_pkt,
    output logic                          clr_valid,
    output logic [IDX_BITS-1:0]           clr_idx,
    output logic                          busy,
    output logic [$clog2(DEPTH):0]        q_count,
    output logic [15:0]                   drop_cnt
);

    localparam int QW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(N + 1);
    localparam int PW = $clog2(WR_PORTS + 1);
`ifdef BP_UPD_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    bp_upd_state_t         state_q, state_d;
    logic [IDX_BITS-1:0]   clr_idx_q, clr_idx_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic [16:0]           drop_sum;

    logic [QW-1:0]         q_count_w;
    logic [CW-1:0]         push_cnt, n_valid;
    bp_upd_entry_t [N-1:0] push_data;
    bp_upd_entry_t         tail_pkt;
    logic                  ovr_en, ovr_taken;
    logic [XLEN-1:0]       ovr_tpc, prev_pc;
    logic                  have_prev;
    logic [PW-1:0]         n_deq;

    bp_upd_fifo #(.N(N), .DEPTH(DEPTH), .WR_PORTS(WR_PORTS)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .ovr_en    (ovr_en),
        .ovr_taken (ovr_taken),
        .ovr_tpc   (ovr_tpc),
        .pop_cnt   (n_deq),
        .head_win  (upd_pkt),
        .tail_pkt  (tail_pkt),
        .count     (q_count_w)
    );

    // Ready uses the pre-dequeue count so it never depends on tbl_stall.
    assign ex_ready = (state_q == RUN) && (q_count_w <= QW'(DEPTH - N));

    always_comb begin
        if (tbl_stall || state_q == INIT)     n_deq = '0;
        else if (q_count_w >= QW'(WR_PORTS))  n_deq = PW'(WR_PORTS);
        else                                  n_deq = PW'(q_count_w);
    end

    // Compact valid lanes in lane order; a coalesced lane folds into the entry just before it.
    always_comb begin
        push_data = '0;
        push_cnt  = '0;
        n_valid   = '0;
        ovr_en    = 1'b0;
        ovr_taken = 1'b0;
        ovr_tpc   = '0;
        have_prev = (q_count_w > QW'(n_deq));
        prev_pc   = tail_pkt.pc;
        for (int i = 0; i < N; i++) begin
            if (ex_valid[i]) begin
                n_valid = n_valid + CW'(1);
                if (COALESCE && ex_cond[i] && have_prev && ex_pc[i] == prev_pc) begin
                    if (push_cnt == '0) begin
                        ovr_en    = 1'b1;
                        ovr_taken = ex_taken[i];
                        ovr_tpc   = ex_tpc[i];
                    end else begin
                        push_data[push_cnt - CW'(1)].taken = ex_taken[i];
                        push_data[push_cnt - CW'(1)].tpc   = ex_tpc[i];
                    end
                end else begin
                    push_data[push_cnt] = '{cond: ex_cond[i], taken: ex_taken[i],
                                            pc: ex_pc[i], tpc: ex_tpc[i]};
                    push_cnt = push_cnt + CW'(1);
                end
                have_prev = 1'b1;
                prev_pc   = ex_pc[i];
            end
        end
        if (!ex_ready) begin
            push_cnt = '0;
            ovr_en   = 1'b0;
        end
    end

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 17'(n_valid);
        drop_cnt_d = drop_cnt_q;
        if (!ex_ready) drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            INIT: begin
                clr_idx_d = clr_idx_q + IDX_BITS'(1);
                if (&clr_idx_q) state_d = RUN;
            end
            RUN: begin
                if (flush_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (q_count_w == '0) begin
                    state_d   = INIT;
                    clr_idx_d = '0;
                end
            end
            default: begin
                state_d   = INIT;
                clr_idx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            clr_idx_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        for (int k = 0; k < WR_PORTS; k++) upd_valid[k] = (q_count_w > QW'(k));
    end

    assign clr_valid = (state_q == INIT);
    assign clr_idx   = clr_idx_q;
    assign busy      = (state_q != RUN) || (q_count_w != '0);
    assign q_count   = q_count_w;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_bp_upd_sched.sv
// Scoreboard bench for bp_upd_sched: a queue-based reference model predicts updates and status.
module tb_bp_upd_sched;
    import bp_upd_sched_pkg::*;

    localparam int N = 3, DEPTH = 8, WR_PORTS = 1, IDX_BITS = 5;
    localparam int SWEEP = 1 << IDX_BITS;
`ifdef BP_UPD_COALESCE_EN
    localparam bit COALESCE_MODEL = 1'b1;
`else
    localparam bit COALESCE_MODEL = 1'b0;
`endif

    logic clock = 1'b0, reset = 1'b1;
    logic [N-1:0] ex_valid = '0, ex_cond = '0, ex_taken = '0;
    logic [N-1:0][XLEN-1:0] ex_pc = '0, ex_tpc = '0;
    logic flush_req = 1'b0, tbl_stall = 1'b0;
    logic ex_ready, clr_valid, busy;
    logic [WR_PORTS-1:0] upd_valid;
    bp_upd_entry_t [WR_PORTS-1:0] upd_pkt;
    logic [IDX_BITS-1:0] clr_idx;
    logic [$clog2(DEPTH):0] q_count;
    logic [15:0] drop_cnt;

    bp_upd_sched #(.N(N), .DEPTH(DEPTH), .WR_PORTS(WR_PORTS), .IDX_BITS(IDX_BITS)) dut (
        .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_cond(ex_cond), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_tpc(ex_tpc), .ex_ready(ex_ready), .flush_req(flush_req),
        .tbl_stall(tbl_stall), .upd_valid(upd_valid), .upd_pkt(upd_pkt), .clr_valid(clr_valid),
        .clr_idx(clr_idx), .busy(busy), .q_count(q_count), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;
    bp_upd_entry_t exp_q[$];
    int mode = 0;          // 0 sweeping, 1 running, 2 draining
    int clr = 0, m_drop = 0;

    logic [N-1:0] nv = '0, nc = '0, nt = '0;
    logic [XLEN-1:0] npc[N], ntpc[N];
    logic nfl = 1'b0, nst = 1'b0, nrst = 1'b1;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every cycle the head of the expected queue must be on upd_pkt[0].
    initial forever begin
        @(negedge clock); #2;
        if (!reset) begin
            chk("upd_valid", upd_valid[0], exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("upd_pkt", upd_pkt[0], exp_q[0]);
                if (!tbl_stall) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        int pre;
        bit rdy;
        bp_upd_entry_t e, t2;
        @(negedge clock);
        reset = nrst; flush_req = nfl; tbl_stall = nst;
        ex_valid = nv; ex_cond = nc; ex_taken = nt;
        for (int i = 0; i < N; i++) begin ex_pc[i] = npc[i]; ex_tpc[i] = ntpc[i]; end
        #1;
        if (nrst) begin
            #2;
            exp_q.delete(); mode = 0; clr = 0; m_drop = 0;
            return;
        end
        pre = exp_q.size();
        rdy = (mode == 1) && (DEPTH - pre >= N);
        chk("ex_ready", ex_ready, rdy);
        chk("clr_valid", clr_valid, mode == 0);
        if (mode == 0) chk("clr_idx", clr_idx, clr);
        chk("busy", busy, (mode != 1) || (pre != 0));
        chk("q_count", q_count, pre);
        chk("drop_cnt", drop_cnt, m_drop);
        #2;  // after the monitor has retired this cycle's pop
        if (rdy) begin
            for (int i = 0; i < N; i++) begin
                if (nv[i]) begin
                    e = '{cond: nc[i], taken: nt[i], pc: npc[i], tpc: ntpc[i]};
                    if (COALESCE_MODEL && nc[i] && exp_q.size() > 0 && exp_q[exp_q.size()-1].pc == npc[i]) begin
                        t2 = exp_q[exp_q.size()-1];
                        t2.taken = nt[i]; t2.tpc = ntpc[i];
                        exp_q[exp_q.size()-1] = t2;
                    end else exp_q.push_back(e);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) if (nv[i]) m_drop++;
            if (m_drop > 65535) m_drop = 65535;
        end
        case (mode)
            0: begin if (clr == SWEEP - 1) mode = 1; clr = (clr + 1) % SWEEP; end
            1: if (nfl) mode = 2;
            default: if (pre == 0) begin mode = 0; clr = 0; end
        endcase
    endtask

    task automatic idle(int n);
        nv = '0; nfl = 1'b0; nst = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_mode(int m, int lim, string nm);
        int k = 0;
        while (mode != m && k < lim) begin tick(); k++; end
        n_tests++;
        if (mode != m) begin
            n_fail++;
            $display("FAIL %s: timed out in mode %0d, required mode %0d", nm, mode, m);
        end
    endtask

    task automatic lanes(logic [N-1:0] v, logic [N-1:0] c, logic [N-1:0] t, logic [XLEN-1:0] base);
        nv = v; nc = c; nt = t;
        for (int i = 0; i < N; i++) begin
            npc[i] = base + XLEN'(4 * i);
            ntpc[i] = 32'h8000 + XLEN'(16 * i) + base;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin npc[i] = '0; ntpc[i] = '0; end
        nrst = 1'b1; tick(); tick(); nrst = 1'b0;

        // Sweep of 32 cycles, then ready and idle on the 33rd.
        idle(SWEEP + 2);

        lanes(3'b111, 3'b101, 3'b001, 32'h100); tick();
        idle(6);

        // Backpressure: two groups fill to 6, the third group is dropped.
        lanes(3'b111, 3'b111, 3'b010, 32'h300); nst = 1'b1; tick();
        lanes(3'b111, 3'b011, 3'b100, 32'h310); tick();
        lanes(3'b111, 3'b111, 3'b111, 32'h320); tick();
        idle(10);

        // Four entries queued, then flush: drain, re-sweep, run.
        lanes(3'b111, 3'b111, 3'b000, 32'h400); nst = 1'b1; tick();
        lanes(3'b001, 3'b000, 3'b001, 32'h410); tick();
        nv = '0; nst = 1'b0; nfl = 1'b1; tick();
        nfl = 1'b0;
        wait_mode(0, 20, "flush_to_init");
        wait_mode(1, SWEEP + 5, "sweep_to_run");
        idle(2);

        // Same-pc cond pair in lanes 0 and 1.
        lanes(3'b011, 3'b011, 3'b010, 32'h200); npc[1] = 32'h200; ntpc[1] = 32'h9999; tick();
        idle(5);

        // Randomized traffic with a small pc pool so same-pc neighbours occur.
        for (int k = 0; k < 600; k++) begin
            nv = N'($urandom_range(0, 7)); nc = N'($urandom_range(0, 7)); nt = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                npc[i] = ($urandom_range(0, 3) == 0) ? XLEN'($urandom) : 32'h200 + XLEN'(4 * $urandom_range(0, 1));
                ntpc[i] = XLEN'($urandom);
            end
            nst = ($urandom_range(0, 9) < 3);
            nfl = ($urandom_range(0, 49) == 0);
            tick();
        end
        nv = '0; nfl = 1'b0; nst = 1'b0;
        wait_mode(1, 3 * SWEEP, "random_settle");
        idle(10);

        // Drop counter saturation under sustained backpressure.
        lanes(3'b111, 3'b000, 3'b000, 32'h500); nst = 1'b1;
        for (int k = 0; k < 22000; k++) tick();
        idle(10);

        // Reset in the middle of a sweep.
        nfl = 1'b1; tick(); nfl = 1'b0;
        begin
            int k = 0;
            while (!(mode == 0 && clr == 17) && k < 100) begin tick(); k++; end
            chk("reach_clr17", clr, 17);
        end
        nrst = 1'b1; tick(); nrst = 1'b0;
        idle(SWEEP + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
